mips_multicycle_ctrl: RTL and testbench

- Main control FSM for the multicycle variant of the MIPS-32 core.
- Sequences one shared ALU, one unified instruction/data memory and the register file across several cycles per instruction.
- Replaces the combinational control unit and the branch AND gate. Emits per-cycle mux selects, write enables and aluControl.
- Supports a memory wait handshake with a timeout trap.

---
 rtl/mips_multicycle_ctrl_pkg.sv | 72 +++++++
 rtl/mips_multicycle_ctrl_if.sv | 33 +++
 rtl/mips_multicycle_ctrl_alu_decoder.sv | 24 ++
 rtl/mips_multicycle_ctrl.sv | 176 +++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS-32 control path: opcodes, funct codes,
// ALU operation codes, mux select encodings and the control FSM states.
package mips_multicycle_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11,
        S_TRAP    = 4'd12
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       branch;
        logic       iord;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic [2:0] alu_control;
        logic       instr_done;
        logic       trap;
    } ctrl_t;

    // States in which the FSM stalls on the memory handshake.
    function automatic logic is_wait_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Control/status bundle between the multicycle control FSM (master) and the datapath (slave).
interface mips_multicycle_ctrl_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pc_en;
    logic       iord;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [2:0] alu_control;
    logic       instr_done;
    logic       trap;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output pc_en, iord, ir_write, mem_read, mem_write, reg_write, reg_dst,
               mem_to_reg, alu_src_a, alu_src_b, pc_src, alu_control, instr_done, trap
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  pc_en, iord, ir_write, mem_read, mem_write, reg_write, reg_dst,
               mem_to_reg, alu_src_a, alu_src_b, pc_src, alu_control, instr_done, trap
    );
endinterface

// File: rtl/mips_multicycle_ctrl_alu_decoder.sv
// R-type funct to ALU operation decoder; shared with the single-cycle control unit.
module mips_multicycle_ctrl_alu_decoder
    import mips_multicycle_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alu_control,
    output logic       illegal
);

    // Unsupported funct codes fall back to add and raise illegal.
    always_comb begin
        alu_control = ALU_ADD;
        illegal     = 1'b0;
        case (funct)
            FN_ADD:  alu_control = ALU_ADD;
            FN_SUB:  alu_control = ALU_SUB;
            FN_AND:  alu_control = ALU_AND;
            FN_OR:   alu_control = ALU_OR;
            FN_SLT:  alu_control = ALU_SLT;
            default: illegal     = 1'b1;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS-32 core: sequences the shared ALU, the unified
// memory and the register file, with a mem_ready handshake and a timeout trap.
module mips_multicycle_ctrl
    import mips_multicycle_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_W        = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    mips_multicycle_ctrl_if.master bus
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

    state_t          state_r;
    logic [TO_W-1:0] to_cnt_r;
    logic [2:0]      fn_alu_s;
    logic            fn_illegal_s;
    logic            timeout_s;
    ctrl_t           ctrl_s;
    ctrl_t           ctrl_gated_s;

    mips_multicycle_ctrl_alu_decoder u_alu_decoder (
        .funct       (bus.funct),
        .alu_control (fn_alu_s),
        .illegal     (fn_illegal_s)
    );

    assign timeout_s = (MEM_TIMEOUT != 0) && !bus.mem_ready && (to_cnt_r == TO_LAST);

    // State register and wait counter; the counter only accumulates consecutive stalled cycles.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r  <= S_FETCH;
            to_cnt_r <= '0;
        end else begin
            if (is_wait_state(state_r) && !bus.mem_ready) begin
                to_cnt_r <= to_cnt_r + TO_W'(1);
            end else begin
                to_cnt_r <= '0;
            end
            case (state_r)
                S_FETCH: begin
                    if (bus.mem_ready)  state_r <= S_DECODE;
                    else if (timeout_s) state_r <= S_TRAP;
                    else                state_r <= S_FETCH;
                end
                S_DECODE: begin
                    case (bus.opcode)
                        OP_LW, OP_SW: state_r <= S_MEMADR;
                        OP_RTYPE:     state_r <= S_EXECUTE;
                        OP_BEQ:       state_r <= S_BRANCH;
                        OP_ADDI:      state_r <= S_ADDIEX;
                        OP_J:         state_r <= S_JUMP;
                        default:      state_r <= S_TRAP;
                    endcase
                end
                S_MEMADR: begin
                    if (bus.opcode == OP_LW) state_r <= S_MEMRD;
                    else                     state_r <= S_MEMWR;
                end
                S_MEMRD: begin
                    if (bus.mem_ready)  state_r <= S_MEMWB;
                    else if (timeout_s) state_r <= S_TRAP;
                    else                state_r <= S_MEMRD;
                end
                S_MEMWR: begin
                    if (bus.mem_ready)  state_r <= S_FETCH;
                    else if (timeout_s) state_r <= S_TRAP;
                    else                state_r <= S_MEMWR;
                end
                S_EXECUTE: begin
                    if (fn_illegal_s) state_r <= S_TRAP;
                    else              state_r <= S_ALUWB;
                end
                S_ADDIEX:                          state_r <= S_ADDIWB;
                S_MEMWB, S_ALUWB, S_BRANCH,
                S_ADDIWB, S_JUMP:                  state_r <= S_FETCH;
                S_TRAP:                            state_r <= S_TRAP;
                default:                           state_r <= S_TRAP;
            endcase
        end
    end

    // Per-state control word; FETCH loads IR/PC only on the cycle memory completes.
    always_comb begin
        ctrl_s             = '0;
        ctrl_s.alu_control = ALU_ADD;
        case (state_r)
            S_FETCH: begin
                ctrl_s.mem_read  = 1'b1;
                ctrl_s.alu_src_b = SRCB_FOUR;
                ctrl_s.ir_write  = bus.mem_ready;
                ctrl_s.pc_write  = bus.mem_ready;
            end
            S_DECODE:  ctrl_s.alu_src_b = SRCB_IMM_SH2;
            S_MEMADR: begin
                ctrl_s.alu_src_a = 1'b1;
                ctrl_s.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                ctrl_s.mem_read = 1'b1;
                ctrl_s.iord     = 1'b1;
            end
            S_MEMWB: begin
                ctrl_s.reg_write  = 1'b1;
                ctrl_s.mem_to_reg = 1'b1;
                ctrl_s.instr_done = 1'b1;
            end
            S_MEMWR: begin
                ctrl_s.mem_write  = 1'b1;
                ctrl_s.iord       = 1'b1;
                ctrl_s.instr_done = bus.mem_ready;
            end
            S_EXECUTE: begin
                ctrl_s.alu_src_a   = 1'b1;
                ctrl_s.alu_src_b   = SRCB_REG;
                ctrl_s.alu_control = fn_alu_s;
            end
            S_ALUWB: begin
                ctrl_s.reg_write  = 1'b1;
                ctrl_s.reg_dst    = 1'b1;
                ctrl_s.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctrl_s.alu_src_a   = 1'b1;
                ctrl_s.alu_src_b   = SRCB_REG;
                ctrl_s.alu_control = ALU_SUB;
                ctrl_s.pc_src      = PCSRC_ALUOUT;
                ctrl_s.branch      = 1'b1;
                ctrl_s.instr_done  = 1'b1;
            end
            S_ADDIEX: begin
                ctrl_s.alu_src_a = 1'b1;
                ctrl_s.alu_src_b = SRCB_IMM;
            end
            S_ADDIWB: begin
                ctrl_s.reg_write  = 1'b1;
                ctrl_s.instr_done = 1'b1;
            end
            S_JUMP: begin
                ctrl_s.pc_src     = PCSRC_JUMP;
                ctrl_s.pc_write   = 1'b1;
                ctrl_s.instr_done = 1'b1;
            end
            S_TRAP:  ctrl_s.trap = 1'b1;
            default: ctrl_s.trap = 1'b1;
        endcase
    end

    // Everything is forced low while reset is held so an abandoned instruction writes nothing.
    always_comb begin
        if (rst) begin
            ctrl_gated_s = ctrl_s;
        end else begin
            ctrl_gated_s = '0;
        end
    end

    assign bus.pc_en       = ctrl_gated_s.pc_write | (ctrl_gated_s.branch & bus.zero);
    assign bus.iord        = ctrl_gated_s.iord;
    assign bus.ir_write    = ctrl_gated_s.ir_write;
    assign bus.mem_read    = ctrl_gated_s.mem_read;
    assign bus.mem_write   = ctrl_gated_s.mem_write;
    assign bus.reg_write   = ctrl_gated_s.reg_write;
    assign bus.reg_dst     = ctrl_gated_s.reg_dst;
    assign bus.mem_to_reg  = ctrl_gated_s.mem_to_reg;
    assign bus.alu_src_a   = ctrl_gated_s.alu_src_a;
    assign bus.alu_src_b   = ctrl_gated_s.alu_src_b;
    assign bus.pc_src      = ctrl_gated_s.pc_src;
    assign bus.alu_control = ctrl_gated_s.alu_control;
    assign bus.instr_done  = ctrl_gated_s.instr_done;
    assign bus.trap        = ctrl_gated_s.trap;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: directed vector table, corner-case sequences and
// randomized instruction streams checked against an instruction-step reference model.
module tb_mips_multicycle_ctrl;

    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;
    localparam logic [5:0] FN_ADD = 6'b100000, FN_SUB = 6'b100010, FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR = 6'b100101, FN_SLT = 6'b101010;
    localparam int TO_DEF = 16;
    localparam int NT = 20;

    typedef struct packed {
        logic       pc_en, iord, ir_write, mem_read, mem_write, reg_write, reg_dst, mem_to_reg, alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic [2:0] alu_control;
        logic       instr_done, trap;
    } outs_t;

    typedef struct {
        logic       r;
        logic [5:0] op;
        logic [5:0] fn;
        logic       rdy;
        logic       z;
        outs_t      exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst0, rst4;
    int   n_checks = 0;
    int   n_fail = 0;
    int   m_pos = 0;
    int   m_waits = 0;
    bit   m_trapped = 1'b0;
    vec_t tbl [NT];

    always #5 clk = ~clk;

    mips_multicycle_ctrl_if bus0 ();
    mips_multicycle_ctrl_if bus4 ();

    mips_multicycle_ctrl #(.MEM_TIMEOUT(TO_DEF), .TO_W(5)) dut (.clk(clk), .rst(rst0), .bus(bus0));
    mips_multicycle_ctrl #(.MEM_TIMEOUT(4), .TO_W(3)) dut4 (.clk(clk), .rst(rst4), .bus(bus4));

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic outs_t mk(input logic pc_en, iord, irw, mrd, mwr, rw, rdst, m2r, sa,
                                 input logic [1:0] sb, input logic [1:0] ps, input logic [2:0] alu,
                                 input logic done, input logic trap);
        outs_t o;
        o = {pc_en, iord, irw, mrd, mwr, rw, rdst, m2r, sa, sb, ps, alu, done, trap};
        return o;
    endfunction

    function automatic outs_t sample0();
        outs_t o;
        o = {bus0.pc_en, bus0.iord, bus0.ir_write, bus0.mem_read, bus0.mem_write, bus0.reg_write,
             bus0.reg_dst, bus0.mem_to_reg, bus0.alu_src_a, bus0.alu_src_b, bus0.pc_src,
             bus0.alu_control, bus0.instr_done, bus0.trap};
        return o;
    endfunction

    // ALU code for an R-type funct, or -1 when the funct is not supported.
    function automatic int alu_of(input logic [5:0] fn);
        case (fn)
            FN_ADD:  return 2;
            FN_SUB:  return 6;
            FN_AND:  return 0;
            FN_OR:   return 1;
            FN_SLT:  return 7;
            default: return -1;
        endcase
    endfunction

    function automatic bit legal_op(input logic [5:0] op);
        return op == OP_R || op == OP_LW || op == OP_SW || op == OP_BEQ || op == OP_ADDI || op == OP_J;
    endfunction

    function automatic int n_cycles(input logic [5:0] op);
        if (op == OP_LW) return 5;
        if (op == OP_SW || op == OP_R || op == OP_ADDI) return 4;
        return 3;
    endfunction

    function automatic bit wait_pos(input logic [5:0] op);
        return m_pos == 0 || (m_pos == 3 && (op == OP_LW || op == OP_SW));
    endfunction

    // Expected outputs for the current step position of the instruction in flight.
    function automatic outs_t model_out(input logic r, input logic [5:0] op, input logic [5:0] fn,
                                        input logic rdy, input logic z, output logic care);
        outs_t o;
        int    code;
        o    = '0;
        care = 1'b1;
        if (!r) return o;
        o.alu_control = 3'b010;
        if (m_trapped) begin
            o.trap = 1'b1;
            return o;
        end
        if (m_pos == 0) begin
            o.mem_read = 1'b1; o.alu_src_b = 2'b01; o.ir_write = rdy; o.pc_en = rdy;
        end else if (m_pos == 1) begin
            o.alu_src_b = 2'b11;
        end else if (op == OP_LW || op == OP_SW) begin
            if (m_pos == 2) begin
                o.alu_src_a = 1'b1; o.alu_src_b = 2'b10;
            end else if (op == OP_LW && m_pos == 3) begin
                o.mem_read = 1'b1; o.iord = 1'b1;
            end else if (op == OP_LW) begin
                o.reg_write = 1'b1; o.mem_to_reg = 1'b1; o.instr_done = 1'b1;
            end else begin
                o.mem_write = 1'b1; o.iord = 1'b1; o.instr_done = rdy;
            end
        end else if (op == OP_R) begin
            if (m_pos == 2) begin
                o.alu_src_a = 1'b1;
                code = alu_of(fn);
                if (code < 0) care = 1'b0;
                else o.alu_control = 3'(code);
            end else begin
                o.reg_write = 1'b1; o.reg_dst = 1'b1; o.instr_done = 1'b1;
            end
        end else if (op == OP_BEQ) begin
            o.alu_src_a = 1'b1; o.alu_control = 3'b110; o.pc_src = 2'b01; o.pc_en = z; o.instr_done = 1'b1;
        end else if (op == OP_ADDI) begin
            if (m_pos == 2) begin
                o.alu_src_a = 1'b1; o.alu_src_b = 2'b10;
            end else begin
                o.reg_write = 1'b1; o.instr_done = 1'b1;
            end
        end else begin
            o.pc_src = 2'b10; o.pc_en = 1'b1; o.instr_done = 1'b1;
        end
        return o;
    endfunction

    task automatic model_adv(input logic r, input logic [5:0] op, input logic [5:0] fn, input logic rdy);
        if (!r) begin
            m_pos = 0; m_trapped = 1'b0; m_waits = 0;
        end else if (!m_trapped) begin
            if (wait_pos(op) && !rdy) begin
                m_waits++;
                if (m_waits == TO_DEF) m_trapped = 1'b1;
            end else begin
                m_waits = 0;
                if (m_pos == 1 && !legal_op(op)) m_trapped = 1'b1;
                else if (m_pos == 2 && op == OP_R && alu_of(fn) < 0) m_trapped = 1'b1;
                else begin
                    m_pos++;
                    if (m_pos == n_cycles(op)) m_pos = 0;
                end
            end
        end
    endtask

    task automatic apply0(input logic r, input logic [5:0] op, input logic [5:0] fn, input logic rdy, input logic z);
        @(negedge clk);
        rst0 = r; bus0.opcode = op; bus0.funct = fn; bus0.mem_ready = rdy; bus0.zero = z;
        #2;
    endtask

    task automatic step(input logic r, input logic [5:0] op, input logic [5:0] fn, input logic rdy,
                        input logic z, input string name, output outs_t got);
        outs_t exp, cmp;
        logic  care;
        apply0(r, op, fn, rdy, z);
        exp = model_out(r, op, fn, rdy, z, care);
        got = sample0();
        cmp = got;
        if (!care) cmp.alu_control = exp.alu_control;
        check(name, 32'(cmp), 32'(exp));
        model_adv(r, op, fn, rdy);
    endtask

    task automatic setv(input int i, input logic r, input logic [5:0] op, input logic [5:0] fn,
                        input logic rdy, input logic z, input outs_t e);
        tbl[i] = '{r, op, fn, rdy, z, e};
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        outs_t     g, z0, f, d, ex_add, ex_sub, ex_or, alu_wb, br1, br0;
        logic      rdy_seq [8];
        logic [5:0] ops [6];
        logic [5:0] fns [5];
        logic [5:0] op, fn;
        logic       r;
        int        n_mem, n_wb, done_at, n_trap, n_done, n_wr;
        logic [7:0] en;

        rst0 = 1'b0; rst4 = 1'b0;
        bus0.opcode = OP_R; bus0.funct = FN_ADD; bus0.mem_ready = 1'b1; bus0.zero = 1'b0;
        bus4.opcode = OP_R; bus4.funct = FN_ADD; bus4.mem_ready = 1'b0; bus4.zero = 1'b0;

        z0     = mk(0,0,0,0,0,0,0,0,0, 2'b00, 2'b00, 3'b000, 0,0);
        f      = mk(1,0,1,1,0,0,0,0,0, 2'b01, 2'b00, 3'b010, 0,0);
        d      = mk(0,0,0,0,0,0,0,0,0, 2'b11, 2'b00, 3'b010, 0,0);
        ex_add = mk(0,0,0,0,0,0,0,0,1, 2'b00, 2'b00, 3'b010, 0,0);
        ex_sub = mk(0,0,0,0,0,0,0,0,1, 2'b00, 2'b00, 3'b110, 0,0);
        ex_or  = mk(0,0,0,0,0,0,0,0,1, 2'b00, 2'b00, 3'b001, 0,0);
        alu_wb = mk(0,0,0,0,0,1,1,0,0, 2'b00, 2'b00, 3'b010, 1,0);
        br1    = mk(1,0,0,0,0,0,0,0,1, 2'b00, 2'b01, 3'b110, 1,0);
        br0    = mk(0,0,0,0,0,0,0,0,1, 2'b00, 2'b01, 3'b110, 1,0);

        setv(0, 0, OP_R, FN_ADD, 1, 0, z0);      setv(1, 0, OP_R, FN_ADD, 1, 0, z0);
        setv(2, 1, OP_R, FN_ADD, 1, 0, f);       setv(3, 1, OP_R, FN_ADD, 1, 0, d);
        setv(4, 1, OP_R, FN_ADD, 1, 0, ex_add);  setv(5, 1, OP_R, FN_ADD, 1, 0, alu_wb);
        setv(6, 1, OP_BEQ, 0, 1, 1, f);          setv(7, 1, OP_BEQ, 0, 1, 1, d);
        setv(8, 1, OP_BEQ, 0, 1, 1, br1);        setv(9, 1, OP_BEQ, 0, 1, 0, f);
        setv(10, 1, OP_BEQ, 0, 1, 0, d);         setv(11, 1, OP_BEQ, 0, 1, 0, br0);
        setv(12, 1, OP_R, FN_SUB, 1, 0, f);      setv(13, 1, OP_R, FN_SUB, 1, 0, d);
        setv(14, 1, OP_R, FN_SUB, 1, 1, ex_sub); setv(15, 1, OP_R, FN_SUB, 1, 0, alu_wb);
        setv(16, 1, OP_R, FN_OR, 1, 0, f);       setv(17, 1, OP_R, FN_OR, 1, 0, d);
        setv(18, 1, OP_R, FN_OR, 1, 0, ex_or);   setv(19, 1, OP_R, FN_OR, 1, 0, alu_wb);

        for (int i = 0; i < NT; i++) begin
            apply0(tbl[i].r, tbl[i].op, tbl[i].fn, tbl[i].rdy, tbl[i].z);
            g = sample0();
            check($sformatf("vec%0d", i), 32'(g), 32'(tbl[i].exp));
            model_adv(tbl[i].r, tbl[i].op, tbl[i].fn, tbl[i].rdy);
        end

        // LW with three stalled memory-read cycles.
        rdy_seq = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        step(0, OP_LW, 0, 1, 0, "lw_reset", g);
        n_mem = 0; n_wb = 0; done_at = 0;
        for (int k = 0; k < 8; k++) begin
            step(1, OP_LW, 0, rdy_seq[k], 0, "lw_seq", g);
            if (g.mem_read && g.iord) n_mem++;
            if (g.reg_write && g.mem_to_reg) n_wb++;
            if (g.instr_done && done_at == 0) done_at = k + 1;
        end
        check("lw_memrd_cycles", 32'(n_mem), 32'd4);
        check("lw_wb_cycles", 32'(n_wb), 32'd1);
        check("lw_latency", 32'(done_at), 32'd8);

        // Illegal opcode traps and stays trapped until reset.
        step(0, 6'h3F, 0, 1, 0, "ill_reset", g);
        step(1, 6'h3F, 0, 1, 0, "ill_fetch", g);
        step(1, 6'h3F, 0, 1, 0, "ill_decode", g);
        n_trap = 0; en = 8'h00;
        for (int k = 0; k < 20; k++) begin
            step(1, 6'h3F, 0, $urandom_range(0, 1), $urandom_range(0, 1), "ill_hold", g);
            if (g.trap) n_trap++;
            en = en | {g.pc_en, g.ir_write, g.mem_read, g.mem_write, g.reg_write, g.instr_done, 2'b00};
        end
        check("trap_persist", 32'(n_trap), 32'd20);
        check("trap_no_enables", 32'(en), 32'd0);
        step(0, OP_R, FN_ADD, 0, 0, "trap_clear_reset", g);
        step(1, OP_R, FN_ADD, 0, 0, "trap_clear_fetch", g);
        check("trap_cleared", 32'({g.trap, g.mem_read}), 32'b01);

        // SW followed by J with memory always ready.
        step(0, OP_SW, 0, 1, 0, "swj_reset", g);
        n_wr = 0; n_done = 0;
        for (int k = 0; k < 4; k++) begin
            step(1, OP_SW, 0, 1, 0, "sw_seq", g);
            if (g.mem_write) n_wr++;
            if (g.instr_done) n_done++;
        end
        for (int k = 0; k < 3; k++) begin
            step(1, OP_J, 0, 1, 0, "j_seq", g);
            if (g.instr_done) n_done++;
        end
        check("sw_write_cycles", 32'(n_wr), 32'd1);
        check("j_pc_src_en", 32'({g.pc_src, g.pc_en}), 32'b101);
        check("swj_done_count", 32'(n_done), 32'd2);

        // SW stalled in the write phase until the default timeout fires.
        step(0, OP_SW, 0, 1, 0, "swto_reset", g);
        for (int k = 0; k < 3; k++) step(1, OP_SW, 0, 1, 0, "swto_pre", g);
        for (int k = 0; k < 18; k++) step(1, OP_SW, 0, 0, 0, "swto_wait", g);
        check("swto_trapped", 32'(g.trap), 32'd1);

        // Short-timeout instance: FETCH starved of mem_ready.
        @(negedge clk);
        rst4 = 1'b0; bus4.mem_ready = 1'b0;
        @(negedge clk);
        rst4 = 1'b1;
        #2;
        check("to4_fetch_start", 32'({bus4.trap, bus4.mem_read, bus4.ir_write}), 32'b010);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            #2;
            check($sformatf("to4_edge%0d", k), 32'({bus4.trap, bus4.ir_write, bus4.pc_en}),
                  32'({(k >= 4), 2'b00}));
        end

        // Randomized instruction streams.
        ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
        fns = '{FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
        op = OP_R; fn = FN_ADD;
        step(0, op, fn, 1, 0, "rnd_reset", g);
        for (int k = 0; k < 4000; k++) begin
            if (m_pos == 0 && !m_trapped) begin
                op = ($urandom_range(0, 11) == 0) ? 6'($urandom) : ops[$urandom_range(0, 5)];
                fn = ($urandom_range(0, 11) == 0) ? 6'($urandom) : fns[$urandom_range(0, 4)];
            end
            if (m_trapped) r = ($urandom_range(0, 3) != 0);
            else           r = ($urandom_range(0, 63) != 0);
            step(r, op, fn, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), "random", g);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
